// File: rtl/tail_light_ctrl_if.sv
// Switch-to-lamp bundle for tail_light_ctrl: raw switch inputs plus lamp and mode outputs.
// master drives the switches; slave (the controller) drives the lamps and mode.
interface tail_light_ctrl_if;
   logic       sw_left;
   logic       sw_right;
   logic       sw_hazard;
   logic       sw_brake;
   logic       LC;
   logic       LB;
   logic       LA;
   logic       RA;
   logic       RB;
   logic       RC;
   logic [1:0] mode;

   modport master (
      output sw_left, sw_right, sw_hazard, sw_brake,
      input  LC, LB, LA, RA, RB, RC, mode
   );

   modport slave (
      input  sw_left, sw_right, sw_hazard, sw_brake,
      output LC, LB, LA, RA, RB, RC, mode
   );
endinterface

// File: rtl/tail_light_ctrl.sv
// Turn/hazard/brake tail-lamp controller: switch sync + optional debounce (TLC_DEBOUNCE_EN),
// step prescaler, hazard > turn > idle sequencer, registered lamp decode with brake overlay.
module tail_light_ctrl #(
   parameter int TICK_DIV = 12_500_000,
   parameter int DEB_LEN  = 16
) (
   input logic              clk,
   input logic              reset,
   tail_light_ctrl_if.slave bus
);
   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      L1     = 4'd1,
      L2     = 4'd2,
      L3     = 4'd3,
      R1     = 4'd4,
      R2     = 4'd5,
      R3     = 4'd6,
      HZ_ON  = 4'd7,
      HZ_OFF = 4'd8
   } state_t;

   // bit order: 0 left, 1 right, 2 hazard, 3 brake
   logic [3:0]    sw_s;
   logic [3:0]    sync1_r;
   logic [3:0]    sync2_r;
   logic [3:0]    d_s;
   logic [PW-1:0] presc_r;
   logic          tick_s;
   state_t        state_r;
   state_t        next_state_s;
   logic          left_ok_s;
   logic          right_ok_s;
   logic [2:0]    left_lamps_s;   // {LC,LB,LA}
   logic [2:0]    right_lamps_s;  // {RC,RB,RA}
   logic [1:0]    mode_s;
   logic [2:0]    left_lamps_r;
   logic [2:0]    right_lamps_r;
   logic [1:0]    mode_r;

   assign sw_s = {bus.sw_brake, bus.sw_hazard, bus.sw_right, bus.sw_left};

   // Two-flop synchroniser for the asynchronous switch pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
      end else begin
         sync1_r <= sw_s;
         sync2_r <= sync1_r;
      end
   end

`ifdef TLC_DEBOUNCE_EN
   localparam int DW = $clog2(DEB_LEN + 1);

   logic [DW-1:0] deb_cnt_r [4];
   logic [3:0]    deb_r;

   // Accept a new level only after DEB_LEN consecutive disagreeing clocks.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_r[i] <= {DW{1'b0}};
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] == deb_r[i]) begin
               deb_cnt_r[i] <= {DW{1'b0}};
            end else if (deb_cnt_r[i] == DW'(DEB_LEN - 1)) begin
               deb_r[i]     <= sync2_r[i];
               deb_cnt_r[i] <= {DW{1'b0}};
            end else begin
               deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
            end
         end
      end
   end

   assign d_s = deb_r;
`else
   localparam int deb_len_unused = DEB_LEN;

   assign d_s = sync2_r;
`endif

   // Free-running step prescaler; never restarted by switch activity.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_r <= {PW{1'b0}};
      end else if (tick_s) begin
         presc_r <= {PW{1'b0}};
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   assign tick_s     = (presc_r == PW'(TICK_DIV - 1));
   assign left_ok_s  = d_s[0] & ~d_s[1];
   assign right_ok_s = d_s[1] & ~d_s[0];

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state: only moves on tick; hazard wins, then a single held turn switch.
   always_comb begin
      next_state_s = state_r;
      if (tick_s) begin
         case (state_r)
            IDLE: begin
               if (d_s[2])          next_state_s = HZ_ON;
               else if (left_ok_s)  next_state_s = L1;
               else if (right_ok_s) next_state_s = R1;
               else                 next_state_s = IDLE;
            end
            L1: begin
               if (d_s[2])         next_state_s = HZ_ON;
               else if (left_ok_s) next_state_s = L2;
               else                next_state_s = IDLE;
            end
            L2: begin
               if (d_s[2])         next_state_s = HZ_ON;
               else if (left_ok_s) next_state_s = L3;
               else                next_state_s = IDLE;
            end
            R1: begin
               if (d_s[2])          next_state_s = HZ_ON;
               else if (right_ok_s) next_state_s = R2;
               else                 next_state_s = IDLE;
            end
            R2: begin
               if (d_s[2])          next_state_s = HZ_ON;
               else if (right_ok_s) next_state_s = R3;
               else                 next_state_s = IDLE;
            end
            L3, R3: begin
               if (d_s[2]) next_state_s = HZ_ON;
               else        next_state_s = IDLE;
            end
            HZ_ON: begin
               if (d_s[2]) next_state_s = HZ_OFF;
               else        next_state_s = IDLE;
            end
            HZ_OFF: begin
               if (d_s[2]) next_state_s = HZ_ON;
               else        next_state_s = IDLE;
            end
            default: next_state_s = IDLE;
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   // Lamp/mode decode of the upcoming state, brake lighting the non-turning side.
   always_comb begin
      left_lamps_s  = 3'b000;
      right_lamps_s = 3'b000;
      mode_s        = 2'b00;
      case (next_state_s)
         IDLE: begin
            left_lamps_s  = {3{d_s[3]}};
            right_lamps_s = {3{d_s[3]}};
            mode_s        = 2'b00;
         end
         L1, L2, L3: begin
            if (next_state_s == L1)      left_lamps_s = 3'b001;
            else if (next_state_s == L2) left_lamps_s = 3'b011;
            else                         left_lamps_s = 3'b111;
            right_lamps_s = {3{d_s[3]}};
            mode_s        = 2'b01;
         end
         R1, R2, R3: begin
            if (next_state_s == R1)      right_lamps_s = 3'b001;
            else if (next_state_s == R2) right_lamps_s = 3'b011;
            else                         right_lamps_s = 3'b111;
            left_lamps_s = {3{d_s[3]}};
            mode_s       = 2'b10;
         end
         HZ_ON: begin
            left_lamps_s  = 3'b111;
            right_lamps_s = 3'b111;
            mode_s        = 2'b11;
         end
         HZ_OFF: begin
            left_lamps_s  = {3{d_s[3]}};
            right_lamps_s = {3{d_s[3]}};
            mode_s        = 2'b11;
         end
         default: begin
            left_lamps_s  = 3'b000;
            right_lamps_s = 3'b000;
            mode_s        = 2'b00;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         left_lamps_r  <= 3'b000;
         right_lamps_r <= 3'b000;
         mode_r        <= 2'b00;
      end else begin
         left_lamps_r  <= left_lamps_s;
         right_lamps_r <= right_lamps_s;
         mode_r        <= mode_s;
      end
   end

   assign bus.LA   = left_lamps_r[0];
   assign bus.LB   = left_lamps_r[1];
   assign bus.LC   = left_lamps_r[2];
   assign bus.RA   = right_lamps_r[0];
   assign bus.RB   = right_lamps_r[1];
   assign bus.RC   = right_lamps_r[2];
   assign bus.mode = mode_r;
endmodule
